// File: rtl/ble_link_sequencer_if.sv
// ble_link_sequencer_if
// Shared UART RX port plus the per-client RX handshakes that the link
// sequencer arbitrates.
//   uart_rx_valid / uart_rx_byte / uart_rd_en  : shared UART receive port
//   rx_byte                                    : received byte, broadcast to all clients
//   setup_/mon_/data_rx_valid                  : per-client "byte available"
//   setup_/mon_/data_rd_en                     : per-client "byte consumed"
// Modports: master = the sequencer (arbiter); slave = UART and clients.
interface ble_link_sequencer_if;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_byte;
  logic       uart_rd_en;
  logic [7:0] rx_byte;
  logic       setup_rx_valid;
  logic       mon_rx_valid;
  logic       data_rx_valid;
  logic       setup_rd_en;
  logic       mon_rd_en;
  logic       data_rd_en;

  modport master (
    input  uart_rx_valid, uart_rx_byte, setup_rd_en, mon_rd_en, data_rd_en,
    output uart_rd_en, rx_byte, setup_rx_valid, mon_rx_valid, data_rx_valid
  );

  modport slave (
    output uart_rx_valid, uart_rx_byte, setup_rd_en, mon_rd_en, data_rd_en,
    input  uart_rd_en, rx_byte, setup_rx_valid, mon_rx_valid, data_rx_valid
  );
endinterface

// File: rtl/ble_link_sequencer.sv
// ble_link_sequencer
// Brings a BLE link up (setup -> advertise -> connected), retries failed
// attempts with a programmable backoff, gives up after a programmable number
// of consecutive failures, and hands the shared UART RX port to whichever
// client owns the current phase.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   link_enable           : level, 1 = keep link up, 0 = shut down
//   setup_done/error      : pulses from the setup client
//   connect               : level from the connection monitor
//   disconnect, timeout   : pulses from the connection monitor
//   regs_max_retries      : consecutive failures allowed
//   regs_backoff_count    : backoff length (cycles in backoff = value + 1)
//   rx                    : UART/client RX bundle (master modport)
//   start_setup           : one-cycle pulse on the first cycle of each setup
//   rx_owner              : 0 none, 1 setup, 2 monitor, 3 data
//   link_up, link_fail    : registered status
//   retry_cnt             : consecutive failed attempts
module ble_link_sequencer #(
  parameter int CNT_W   = 24,
  parameter int RETRY_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                link_enable,
  input  logic                setup_done,
  input  logic                setup_error,
  input  logic                connect,
  input  logic                disconnect,
  input  logic                timeout,
  input  logic [RETRY_W-1:0]  regs_max_retries,
  input  logic [CNT_W-1:0]    regs_backoff_count,
  ble_link_sequencer_if.master rx,
  output logic                start_setup,
  output logic [1:0]          rx_owner,
  output logic                link_up,
  output logic                link_fail,
  output logic [RETRY_W-1:0]  retry_cnt
);

  typedef enum logic [2:0] {
    S_OFF,
    S_SETUP,
    S_ADVERTISE,
    S_CONNECTED,
    S_BACKOFF,
    S_FAILED
  } state_t;

  localparam logic [RETRY_W-1:0] RETRY_ONE = {{(RETRY_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 start_setup_q, start_setup_d;
  logic                 link_up_q, link_up_d;
  logic                 link_fail_q, link_fail_d;
  logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0]     backoff_q, backoff_d;
  logic                 connect_seen_q, connect_seen_d;  // connect was high last cycle in advertise
  logic                 fail_evt;
  logic [RETRY_W-1:0]   retry_inc;

  // Saturating increment of the failure counter.
  assign retry_inc = (retry_cnt_q == '1) ? retry_cnt_q : retry_cnt_q + RETRY_ONE;

  always_comb begin
    state_d        = state_q;
    start_setup_d  = 1'b0;
    retry_cnt_d    = retry_cnt_q;
    backoff_d      = backoff_q;
    connect_seen_d = 1'b0;
    fail_evt       = 1'b0;

    // Dropping link_enable beats every other event, including a pulse
    // arriving in the same cycle.
    if (!link_enable) begin
      state_d     = S_OFF;
      retry_cnt_d = '0;
      backoff_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d       = S_SETUP;
          start_setup_d = 1'b1;
        end
        S_SETUP: begin
          if (setup_error) begin
            fail_evt = 1'b1;           // error wins over a simultaneous done
          end else if (setup_done) begin
            state_d = S_ADVERTISE;
          end
        end
        S_ADVERTISE: begin
          if (timeout) begin
            fail_evt = 1'b1;
          end else if (connect && connect_seen_q) begin
            state_d     = S_CONNECTED;
            retry_cnt_d = '0;
          end else begin
            connect_seen_d = connect;
          end
        end
        S_CONNECTED: begin
          // Losing an established link restarts setup without counting a failure.
          if (disconnect || timeout) begin
            state_d       = S_SETUP;
            start_setup_d = 1'b1;
          end
        end
        S_BACKOFF: begin
          if (backoff_q == '0) begin
            state_d       = S_SETUP;
            start_setup_d = 1'b1;
          end else begin
            backoff_d = backoff_q - CNT_ONE;
          end
        end
        S_FAILED: begin
          state_d = S_FAILED;
        end
        default: begin
          state_d = S_OFF;
        end
      endcase

      if (fail_evt) begin
        retry_cnt_d = retry_inc;
        if (retry_inc >= regs_max_retries) begin
          state_d = S_FAILED;
        end else begin
          state_d   = S_BACKOFF;
          backoff_d = regs_backoff_count;
        end
      end
    end

    link_up_d   = (state_d == S_CONNECTED);
    link_fail_d = (state_d == S_FAILED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_OFF;
      start_setup_q  <= 1'b0;
      link_up_q      <= 1'b0;
      link_fail_q    <= 1'b0;
      retry_cnt_q    <= '0;
      backoff_q      <= '0;
      connect_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_setup_q  <= start_setup_d;
      link_up_q      <= link_up_d;
      link_fail_q    <= link_fail_d;
      retry_cnt_q    <= retry_cnt_d;
      backoff_q      <= backoff_d;
      connect_seen_q <= connect_seen_d;
    end
  end

  assign start_setup = start_setup_q;
  assign link_up     = link_up_q;
  assign link_fail   = link_fail_q;
  assign retry_cnt   = retry_cnt_q;

  // RX arbitration follows the current state, so ownership only moves on a
  // state transition and an rd_en issued this cycle is routed to the owner
  // that was valid this cycle.
  always_comb begin
    rx_owner          = 2'd0;
    rx.uart_rd_en     = 1'b0;
    rx.setup_rx_valid = 1'b0;
    rx.mon_rx_valid   = 1'b0;
    rx.data_rx_valid  = 1'b0;
    case (state_q)
      S_SETUP: begin
        rx_owner          = 2'd1;
        rx.setup_rx_valid = rx.uart_rx_valid;
        rx.uart_rd_en     = rx.setup_rd_en;
      end
      S_ADVERTISE: begin
        rx_owner        = 2'd2;
        rx.mon_rx_valid = rx.uart_rx_valid;
        rx.uart_rd_en   = rx.mon_rd_en;
      end
      S_CONNECTED: begin
        // Monitor snoops the stream (e.g. OK+DISC); only the data client consumes.
        rx_owner         = 2'd3;
        rx.data_rx_valid = rx.uart_rx_valid;
        rx.mon_rx_valid  = rx.uart_rx_valid;
        rx.uart_rd_en    = rx.data_rd_en;
      end
      default: begin
        rx_owner = 2'd0;          // nobody reads; bytes wait in the UART
      end
    endcase
  end

  assign rx.rx_byte = rx.uart_rx_byte;

endmodule

// File: tb/tb_ble_link_sequencer.sv
module tb_ble_link_sequencer;

  logic        clk;
  logic        rst_n;
  logic        link_enable, setup_done, setup_error, connect, disconnect, timeout;
  logic [3:0]  regs_max_retries;
  logic [23:0] regs_backoff_count;
  logic        start_setup;
  logic [1:0]  rx_owner;
  logic        link_up, link_fail;
  logic [3:0]  retry_cnt;

  int total = 0;
  int bad   = 0;

  ble_link_sequencer_if bus ();

  ble_link_sequencer #(.CNT_W(24), .RETRY_W(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .link_enable        (link_enable),
    .setup_done         (setup_done),
    .setup_error        (setup_error),
    .connect            (connect),
    .disconnect         (disconnect),
    .timeout            (timeout),
    .regs_max_retries   (regs_max_retries),
    .regs_backoff_count (regs_backoff_count),
    .rx                 (bus),
    .start_setup        (start_setup),
    .rx_owner           (rx_owner),
    .link_up            (link_up),
    .link_fail          (link_fail),
    .retry_cnt          (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       le, sd, se, cn, dc, to, uv;
    logic [7:0] ub;
    logic       srd, mrd, drd;
    logic       e_start;
    logic [1:0] e_owner;
    logic       e_up, e_fail;
    logic [3:0] e_retry;
    logic       e_rd, e_sv, e_mv, e_dv;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    link_enable = 1'b0; setup_done = 1'b0; setup_error = 1'b0;
    connect = 1'b0; disconnect = 1'b0; timeout = 1'b0;
    bus.uart_rx_valid = 1'b0; bus.uart_rx_byte = 8'h00;
    bus.setup_rd_en = 1'b0; bus.mon_rd_en = 1'b0; bus.data_rd_en = 1'b0;
  endtask

  int cnt;
  int pulses;

  initial begin
    // Each row: inputs driven for one cycle, outputs expected in that cycle
    // (before the next rising edge). max_retries=3, backoff=2.
    //          le sd se cn dc to uv ub     srd mrd drd | st own up fl rty rd sv mv dv
    vecs[0]  = '{0,0,0,0,0,0,0,8'h00,0,0,0, 0,2'd0,0,0,4'd0,0,0,0,0}; // idle in OFF
    vecs[1]  = '{1,0,0,0,0,0,0,8'h00,0,0,0, 0,2'd0,0,0,4'd0,0,0,0,0}; // enable requested
    vecs[2]  = '{1,0,0,0,0,0,0,8'h00,0,0,0, 1,2'd1,0,0,4'd0,0,0,0,0}; // first SETUP cycle
    vecs[3]  = '{1,0,0,0,0,0,1,8'h55,1,0,1, 0,2'd1,0,0,4'd0,1,1,0,0}; // setup owns RX
    vecs[4]  = '{1,1,0,0,0,0,0,8'h00,0,0,0, 0,2'd1,0,0,4'd0,0,0,0,0}; // setup_done
    vecs[5]  = '{1,0,0,1,0,0,1,8'h10,1,0,0, 0,2'd2,0,0,4'd0,0,0,1,0}; // ADV, setup rd ignored
    vecs[6]  = '{1,0,0,1,0,0,0,8'h00,0,0,0, 0,2'd2,0,0,4'd0,0,0,0,0}; // second connect cycle
    vecs[7]  = '{1,0,0,1,0,0,1,8'h41,0,0,1, 0,2'd3,1,0,4'd0,1,0,1,1}; // data reads 0x41
    vecs[8]  = '{1,0,0,1,0,0,1,8'h42,0,1,0, 0,2'd3,1,0,4'd0,0,0,1,1}; // monitor rd ignored
    vecs[9]  = '{1,0,0,0,1,0,0,8'h00,0,0,0, 0,2'd3,1,0,4'd0,0,0,0,0}; // disconnect
    vecs[10] = '{1,0,0,0,0,0,0,8'h00,0,0,0, 1,2'd1,0,0,4'd0,0,0,0,0}; // back in SETUP, pulse
    vecs[11] = '{0,1,0,0,0,0,0,8'h00,0,0,0, 0,2'd1,0,0,4'd0,0,0,0,0}; // done with enable low
    vecs[12] = '{0,0,0,0,0,0,0,8'h00,0,0,0, 0,2'd0,0,0,4'd0,0,0,0,0}; // OFF, not ADV

    clear_inputs();
    regs_max_retries   = 4'd3;
    regs_backoff_count = 24'd2;
    rst_n = 1'b0;
    #12;
    chk("rst_owner", 32'(rx_owner), 32'd0);
    chk("rst_start", 32'(start_setup), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      tick();
      link_enable = vecs[i].le; setup_done = vecs[i].sd; setup_error = vecs[i].se;
      connect = vecs[i].cn; disconnect = vecs[i].dc; timeout = vecs[i].to;
      bus.uart_rx_valid = vecs[i].uv; bus.uart_rx_byte = vecs[i].ub;
      bus.setup_rd_en = vecs[i].srd; bus.mon_rd_en = vecs[i].mrd; bus.data_rd_en = vecs[i].drd;
      #1;
      $display("vec %0d: owner=%0d start=%0b up=%0b fail=%0b retry=%0d rd=%0b sv=%0b mv=%0b dv=%0b",
               i, rx_owner, start_setup, link_up, link_fail, retry_cnt, bus.uart_rd_en,
               bus.setup_rx_valid, bus.mon_rx_valid, bus.data_rx_valid);
      chk($sformatf("v%0d_start", i), 32'(start_setup), 32'(vecs[i].e_start));
      chk($sformatf("v%0d_owner", i), 32'(rx_owner), 32'(vecs[i].e_owner));
      chk($sformatf("v%0d_up", i), 32'(link_up), 32'(vecs[i].e_up));
      chk($sformatf("v%0d_fail", i), 32'(link_fail), 32'(vecs[i].e_fail));
      chk($sformatf("v%0d_retry", i), 32'(retry_cnt), 32'(vecs[i].e_retry));
      chk($sformatf("v%0d_uart_rd", i), 32'(bus.uart_rd_en), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_setup_v", i), 32'(bus.setup_rx_valid), 32'(vecs[i].e_sv));
      chk($sformatf("v%0d_mon_v", i), 32'(bus.mon_rx_valid), 32'(vecs[i].e_mv));
      chk($sformatf("v%0d_data_v", i), 32'(bus.data_rx_valid), 32'(vecs[i].e_dv));
      if (vecs[i].uv) chk($sformatf("v%0d_byte", i), 32'(bus.rx_byte), 32'(vecs[i].ub));
    end

    // ---------------- retries with backoff 10, max 3 ----------------
    tick();
    clear_inputs();
    regs_max_retries   = 4'd3;
    regs_backoff_count = 24'd10;
    tick();
    link_enable = 1'b1;
    tick();
    #1 chk("A_start0", 32'(start_setup), 32'd1);
    setup_done = 1'b1;
    tick();
    setup_done = 1'b0;
    #1 chk("A_adv", 32'(rx_owner), 32'd2);
    for (int k = 1; k <= 3; k++) begin
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      #1;
      if (k < 3) begin
        cnt = 0;
        while (rx_owner == 2'd0 && cnt < 100) begin
          cnt++;
          tick();
          #1;
        end
        $display("backoff %0d: cycles=%0d retry=%0d", k, cnt, retry_cnt);
        chk($sformatf("A_backoff%0d_len", k), 32'(cnt), 32'd11);
        chk($sformatf("A_backoff%0d_start", k), 32'(start_setup), 32'd1);
        chk($sformatf("A_backoff%0d_retry", k), 32'(retry_cnt), 32'(k));
        setup_done = 1'b1;
        tick();
        setup_done = 1'b0;
        #1;
      end else begin
        chk("A_fail", 32'(link_fail), 32'd1);
        chk("A_retry3", 32'(retry_cnt), 32'd3);
      end
    end
    pulses = 0;
    repeat (20) begin
      tick();
      #1;
      if (start_setup) pulses++;
    end
    chk("A_no_more_start", 32'(pulses), 32'd0);
    chk("A_still_fail", 32'(link_fail), 32'd1);
    link_enable = 1'b0;
    tick();
    #1;
    chk("A_off_fail", 32'(link_fail), 32'd0);
    chk("A_off_retry", 32'(retry_cnt), 32'd0);
    $display("retry sequence: fail=%0b retry=%0d", link_fail, retry_cnt);

    // ---------------- async reset during backoff ----------------
    link_enable = 1'b1;
    tick();
    setup_done = 1'b1;
    tick();
    setup_done = 1'b0;
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    tick();
    tick();
    bus.uart_rx_valid = 1'b1; bus.setup_rd_en = 1'b1; bus.data_rd_en = 1'b1; bus.mon_rd_en = 1'b1;
    #1 chk("B_in_backoff_retry", 32'(retry_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("B_rst_retry", 32'(retry_cnt), 32'd0);
    chk("B_rst_owner", 32'(rx_owner), 32'd0);
    chk("B_rst_uart_rd", 32'(bus.uart_rd_en), 32'd0);
    chk("B_rst_valids", 32'({bus.setup_rx_valid, bus.mon_rx_valid, bus.data_rx_valid}), 32'd0);
    chk("B_rst_flags", 32'({start_setup, link_up, link_fail}), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.mon_rd_en = 1'b0; bus.data_rd_en = 1'b0;
    tick();
    #1;
    chk("B_restart_start", 32'(start_setup), 32'd1);
    chk("B_restart_owner", 32'(rx_owner), 32'd1);
    chk("B_restart_setup_v", 32'(bus.setup_rx_valid), 32'd1);
    $display("reset sequence: start=%0b owner=%0d", start_setup, rx_owner);
    bus.uart_rx_valid = 1'b0; bus.setup_rd_en = 1'b0;

    // ---------------- max_retries=0, backoff=0, corner events ----------------
    regs_max_retries = 4'd0;
    setup_error = 1'b1;
    tick();
    setup_error = 1'b0;
    #1;
    chk("C_max0_fail", 32'(link_fail), 32'd1);
    chk("C_max0_retry", 32'(retry_cnt), 32'd1);
    link_enable = 1'b0;
    tick();
    #1 chk("C_off_owner", 32'(rx_owner), 32'd0);
    regs_max_retries   = 4'd2;
    regs_backoff_count = 24'd0;
    link_enable = 1'b1;
    tick();
    setup_done = 1'b1; setup_error = 1'b1;
    tick();
    setup_done = 1'b0; setup_error = 1'b0;
    #1;
    chk("C_err_wins_owner", 32'(rx_owner), 32'd0);
    chk("C_err_wins_retry", 32'(retry_cnt), 32'd1);
    tick();
    #1;
    chk("C_bo0_owner", 32'(rx_owner), 32'd1);
    chk("C_bo0_start", 32'(start_setup), 32'd1);
    setup_done = 1'b1;
    tick();
    setup_done = 1'b0;
    connect = 1'b1;
    tick();
    connect = 1'b0;
    tick();
    connect = 1'b1;
    tick();
    #1 chk("C_gap_stays_adv", 32'(rx_owner), 32'd2);
    tick();
    #1;
    chk("C_conn_owner", 32'(rx_owner), 32'd3);
    chk("C_conn_retry_clr", 32'(retry_cnt), 32'd0);
    chk("C_conn_up", 32'(link_up), 32'd1);
    connect = 1'b0; disconnect = 1'b1; timeout = 1'b1;
    tick();
    disconnect = 1'b0; timeout = 1'b0;
    #1;
    chk("C_disc_owner", 32'(rx_owner), 32'd1);
    chk("C_disc_start", 32'(start_setup), 32'd1);
    chk("C_disc_up", 32'(link_up), 32'd0);
    chk("C_disc_retry", 32'(retry_cnt), 32'd0);
    tick();
    #1 chk("C_single_pulse", 32'(start_setup), 32'd0);
    $display("corner sequence: owner=%0d retry=%0d", rx_owner, retry_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ble_link_sequencer.md
BLE_LINK_SEQUENCER -- requirements
Module: ble_link_sequencer

Interface
REQ-001 Parameter CNT_W, default 24, width of the backoff counter and of regs_backoff_count.
REQ-002 Parameter RETRY_W, default 4, width of the retry counter and of regs_max_retries.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 link_enable  input  1  level; 1 = bring the link up and keep it up; 0 = shut it down.
REQ-006 setup_done / setup_error  input  1 each  pulses from BLE setup.
REQ-007 connect  input  1  level from the connection monitor; disconnect, timeout  input  1 each  pulses from the monitor.
REQ-008 regs_max_retries  input  RETRY_W  consecutive failed attempts allowed; regs_backoff_count  input  CNT_W  backoff length in clk cycles.
REQ-009 uart_rx_valid  input  1; uart_rx_byte  input  8; uart_rd_en  output  1  shared UART RX port.
REQ-010 setup_rx_valid, mon_rx_valid, data_rx_valid  output  1 each; setup_rd_en, mon_rd_en, data_rd_en  input  1 each  per-client RX handshake; the byte is broadcast to all clients on rx_byte  output  8.
REQ-011 start_setup  output  1  pulse; rx_owner  output  2  (0 none, 1 setup, 2 monitor, 3 data); link_up  output  1; link_fail  output  1; retry_cnt  output  RETRY_W.

Function
REQ-012 States: S_OFF, S_SETUP, S_ADVERTISE, S_CONNECTED, S_BACKOFF, S_FAILED; one transition per cycle at most.
REQ-013 S_OFF: link_enable=1 -> S_SETUP; start_setup=1 for exactly the first cycle spent in S_SETUP (registered, one cycle after entry is decided).
REQ-014 S_SETUP: setup_done -> S_ADVERTISE; setup_error -> failure handling (REQ-018).
REQ-015 S_ADVERTISE: connect=1 for 2 consecutive cycles -> S_CONNECTED, retry_cnt cleared to 0; timeout -> failure handling.
REQ-016 S_CONNECTED: link_up=1; disconnect or timeout -> S_SETUP with a new start_setup pulse; retry_cnt is not incremented.
REQ-017 S_BACKOFF: counter loads regs_backoff_count on entry and decrements each cycle; at 0 -> S_SETUP with a start_setup pulse; regs_backoff_count=0 means exactly 1 cycle in S_BACKOFF.
REQ-018 Failure handling: retry_cnt increments, saturating at all-ones; if the new value >= regs_max_retries -> S_FAILED, else -> S_BACKOFF.
REQ-019 regs_max_retries=0: the first failure goes directly to S_FAILED.
REQ-020 S_FAILED: link_fail=1; exits only when link_enable=0 -> S_OFF, which clears retry_cnt and link_fail.
REQ-021 link_enable=0 in any state -> S_OFF next cycle; this has priority over every other event and discards a simultaneous pulse.
REQ-022 Simultaneous setup_done and setup_error: setup_error wins; simultaneous disconnect and timeout are treated as a single event.
REQ-023 rx_owner (combinational from state): S_SETUP=1, S_ADVERTISE=2, S_CONNECTED=3, all other states=0.
REQ-024 Only the owning client sees *_rx_valid=uart_rx_valid; all other clients see 0. uart_rd_en = the owner's rd_en; other clients' rd_en are ignored.
REQ-025 In S_CONNECTED, mon_rx_valid is also driven, with monitor rd_en ignored, so the monitor can snoop OK+DISC while the data client consumes bytes.
REQ-026 rx_owner=0: uart_rd_en=0 and bytes stay pending in the UART; none are dropped.
REQ-027 Ownership changes only at state transitions; an rd_en already issued is honoured for the cycle in which it was issued.

Reset
REQ-028 While rst_n=0: state=S_OFF, start_setup=0, link_up=0, link_fail=0, retry_cnt=0, backoff counter=0, rx_owner=0, uart_rd_en=0, all *_rx_valid=0.
REQ-029 Reset asserted mid-operation aborts immediately; after release, the block re-enters S_SETUP only if link_enable=1.

Verification
REQ-030 link_enable=1, then setup_done, then connect held 2 cycles -> exactly one start_setup pulse, rx_owner sequence 1,2,3, link_up=1, retry_cnt=0.
REQ-031 regs_max_retries=3, regs_backoff_count=10, three timeouts in S_ADVERTISE -> two backoffs of 11 cycles each, retry_cnt=3, link_fail=1, and no further start_setup.
REQ-032 In S_CONNECTED, data_rd_en=1 with uart_rx_valid=1 and byte 0x41 -> uart_rd_en=1, data_rx_valid=1, mon_rx_valid=1, setup_rx_valid=0.
REQ-033 In S_CONNECTED, a disconnect pulse -> S_SETUP next cycle, start_setup pulse, link_up=0, retry_cnt unchanged.
REQ-034 link_enable dropped in the same cycle as setup_done -> S_OFF, no S_ADVERTISE entry.
REQ-035 rst_n pulsed low during S_BACKOFF -> all outputs take their reset values asynchronously; with link_enable=1 after release, a new start_setup pulse follows.
